pulse_stretch_tx: RTL
=====================

PULSE_STRETCH_TX -- requirements
Module: pulse_stretch_tx

Interface
REQ-001 SHALL have parameter STRETCH, default 3, number of clka cycles level_out is held high per transferred pulse (legal 1..255).
REQ-002 SHALL have parameter GAP, default 3, minimum clka cycles level_out is held low between transferred pulses (legal 1..255).
REQ-003 SHALL have parameter PEND_W, default 4, width of the pending-pulse counter (legal 1..8).
REQ-004 SHALL have port clka  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port pulse_in  input  1  single-cycle event request, sampled every clka edge.
REQ-007 SHALL have port level_out  output  1  registered stretched level for capture by a slower domain's synchronizer/edge detector.
REQ-008 SHALL have port busy  output  1  registered; high whenever state is not IDLE or pending count is non-zero.
REQ-009 SHALL have port pend_cnt  output  PEND_W  registered count of accepted pulses not yet transmitted.
REQ-010 SHALL have port ovf  output  1  registered sticky flag; set when a pulse is dropped.

Function
REQ-011 SHALL implement FSM states IDLE, HIGH, LOW, with a phase counter wide enough for max(STRETCH, GAP).
REQ-012 SHALL, in IDLE with pulse_in=1, enter HIGH at the next edge, with level_out=1 starting in that cycle (1-cycle latency).
REQ-013 SHALL, in HIGH, hold level_out=1 for exactly STRETCH cycles, then enter LOW.
REQ-014 SHALL, in LOW, hold level_out=0 for exactly GAP cycles; on the last LOW cycle, enter HIGH if pend_cnt>0 or pulse_in=1; otherwise enter IDLE.
REQ-015 SHALL increment pend_cnt when pulse_in=1 and the pulse is not consumed that cycle. A pulse is consumed when it is in IDLE, or in the last LOW cycle with pend_cnt=0.
REQ-016 SHALL decrement pend_cnt on the last LOW cycle when pend_cnt>0. If pulse_in=1 in the same cycle, pend_cnt is unchanged (net zero) and no pulse is lost.
REQ-017 SHALL saturate pend_cnt at 2^PEND_W-1. A non-consumed pulse arriving at saturation is dropped and sets ovf.
REQ-018 SHALL keep ovf set until reset.
REQ-019 SHALL transmit exactly one high interval per accepted pulse, in arrival order, with no merging of adjacent intervals.
REQ-020 SHALL use no combinational path from pulse_in to any output.

Reset
REQ-021 SHALL, on a rising clka edge with rst_n=0, set: state=IDLE, phase counter=0, level_out=0, busy=0, pend_cnt=0, ovf=0.
REQ-022 SHALL, when reset is asserted mid-HIGH or mid-LOW, abort the transfer and discard pending pulses. level_out=0 in the first cycle after that edge.
REQ-023 SHALL ignore pulse_in while rst_n=0.

Configuration
REQ-024 SHALL support macro PULSE_STRETCH_DROP_CNT_EN.
- Defined: adds output drop_cnt  output  8, a registered count of dropped pulses that saturates at 255 and is reset to 0.
- Undefined: port drop_cnt and its logic are absent, and all other behaviour is identical.

Verification
REQ-025 SHALL cover: STRETCH=3, GAP=3, single pulse_in at cycle 10 -> level_out high cycles 11-13, low 14-16, IDLE at 17, busy low from 17.
REQ-026 SHALL cover: pulses at cycles 10, 11, 12 -> pend_cnt peaks at 2; three high intervals start at 11, 17, 23; pend_cnt=0 after cycle 22.
REQ-027 SHALL cover: pulse_in on the last LOW cycle with pend_cnt=1 -> pend_cnt stays 1, next HIGH starts the following cycle, and two further intervals are transmitted.
REQ-028 SHALL cover: PEND_W=2, 6 back-to-back pulses starting from IDLE -> pend_cnt saturates at 3, ovf=1, 4 intervals transmitted; drop_cnt=2 with PULSE_STRETCH_DROP_CNT_EN defined.
REQ-029 SHALL cover: rst_n=0 for one edge during the second HIGH cycle, with pend_cnt=2 -> next cycle level_out=0, pend_cnt=0, ovf=0, state IDLE.
REQ-030 SHALL cover: STRETCH=1, GAP=1, pulse_in held high for 4 cycles -> level_out toggles 1,0,1,0,... for exactly 4 intervals, with no ovf at PEND_W=4.

Source files
------------

// File: rtl/pulse_stretch_tx.sv
// pulse_stretch_tx: turns single-cycle events on clka into stretched
// high intervals (STRETCH cycles high, at least GAP cycles low). A slower
// clock domain can then see each event through its synchronizer and edge
// detector. Events that arrive while an interval is in flight are queued
// as a pending count and are sent in arrival order.
// Optional feature: define PULSE_STRETCH_DROP_CNT_EN to add the drop_cnt
// output, a saturating count of dropped pulses.
module pulse_stretch_tx #(
    parameter int STRETCH = 3,
    parameter int GAP     = 3,
    parameter int PEND_W  = 4
) (
    input  logic              clka,
    input  logic              rst_n,
    input  logic              pulse_in,
    output logic              level_out,
    output logic              busy,
    output logic [PEND_W-1:0] pend_cnt,
    output logic              ovf
`ifdef PULSE_STRETCH_DROP_CNT_EN
    ,
    output logic [7:0]        drop_cnt
`endif
);

    localparam int MAX_PHASE = (STRETCH > GAP) ? STRETCH : GAP;
    localparam int CNT_W     = (MAX_PHASE > 1) ? $clog2(MAX_PHASE) : 1;

    localparam logic [CNT_W-1:0]  HIGH_LOAD = CNT_W'(STRETCH - 1);
    localparam logic [CNT_W-1:0]  LOW_LOAD  = CNT_W'(GAP - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t             state;
    state_t             nxt_state;
    logic [CNT_W-1:0]   phase;
    logic [CNT_W-1:0]   nxt_phase;
    logic [PEND_W-1:0]  nxt_pend;
    logic               last_low;
    logic               consumed;
    logic               drop;

    // Saturating 8-bit increment for the drop counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Next-state, phase and pending-count decisions for the current cycle.
    // phase counts down the cycles remaining in HIGH or LOW; zero marks the
    // last cycle of that state.
    always_comb begin
        nxt_state = state;
        nxt_phase = phase;
        nxt_pend  = pend_cnt;
        drop      = 1'b0;
        last_low  = (state == LOW) && (phase == '0);
        // A pulse starts a transfer immediately if nothing is queued ahead
        // of it and the transmitter is free to start one next cycle.
        consumed  = pulse_in && ((state == IDLE) || (last_low && (pend_cnt == '0)));

        case (state)
            IDLE: begin
                if (pulse_in) begin
                    nxt_state = HIGH;
                    nxt_phase = HIGH_LOAD;
                end
            end
            HIGH: begin
                if (phase == '0) begin
                    nxt_state = LOW;
                    nxt_phase = LOW_LOAD;
                end else begin
                    nxt_phase = phase - CNT_W'(1);
                end
            end
            LOW: begin
                if (phase == '0) begin
                    if ((pend_cnt != '0) || pulse_in) begin
                        nxt_state = HIGH;
                        nxt_phase = HIGH_LOAD;
                    end else begin
                        nxt_state = IDLE;
                        nxt_phase = '0;
                    end
                end else begin
                    nxt_phase = phase - CNT_W'(1);
                end
            end
            default: begin
                nxt_state = IDLE;
                nxt_phase = '0;
            end
        endcase

        // Dequeue on the last LOW cycle; a simultaneous new pulse takes the
        // freed slot, so the count stays put and nothing is lost.
        if (last_low && (pend_cnt != '0)) begin
            if (!pulse_in) begin
                nxt_pend = pend_cnt - PEND_W'(1);
            end
        end else if (pulse_in && !consumed) begin
            if (pend_cnt == PEND_MAX) begin
                drop = 1'b1;
            end else begin
                nxt_pend = pend_cnt + PEND_W'(1);
            end
        end
    end

    // State, phase and all outputs are registered; reset aborts any transfer
    // and discards queued pulses.
    always_ff @(posedge clka) begin
        if (!rst_n) begin
            state     <= IDLE;
            phase     <= '0;
            level_out <= 1'b0;
            busy      <= 1'b0;
            pend_cnt  <= '0;
            ovf       <= 1'b0;
`ifdef PULSE_STRETCH_DROP_CNT_EN
            drop_cnt  <= 8'd0;
`endif
        end else begin
            state     <= nxt_state;
            phase     <= nxt_phase;
            level_out <= (nxt_state == HIGH);
            busy      <= (nxt_state != IDLE) || (nxt_pend != '0);
            pend_cnt  <= nxt_pend;
            ovf       <= ovf | drop;
`ifdef PULSE_STRETCH_DROP_CNT_EN
            if (drop) begin
                drop_cnt <= sat_inc8(drop_cnt);
            end
`endif
        end
    end

endmodule
